// File: rtl/apb_master_fsm.sv
// APB requester: turns one decoded bridge request into an APB SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master_fsm #(
  parameter logic [31:0] SLV0_BASE      = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE      = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE      = 32'h8800_0000,
  parameter logic [31:0] SLV_SIZE       = 32'h0400_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  pselx,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  if ((SLV_SIZE == 32'd0) || ((SLV_SIZE & (SLV_SIZE - 32'd1)) != 32'd0)) begin : g_size_chk
    $error("SLV_SIZE must be a non-zero power of two");
  end
  if (TIMEOUT_CYCLES > 255) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state;
  logic [2:0] dec_sel;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
`endif

  // Offset-from-base compare cannot overflow even for a window at the top of the map.
  always_comb begin
    dec_sel = 3'b000;
    if ((req_addr - SLV0_BASE) < SLV_SIZE) dec_sel[0] = 1'b1;
    if ((req_addr - SLV1_BASE) < SLV_SIZE) dec_sel[1] = 1'b1;
    if ((req_addr - SLV2_BASE) < SLV_SIZE) dec_sel[2] = 1'b1;
  end

  assign req_ready = (state == IDLE);

  // NOTE: every register here updates with <= so all of them see pre-edge values,
  // and all of them (including the data registers) get a defined reset value.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= IDLE;
      pselx     <= 3'b000;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= 8'h0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (|dec_sel) begin
              pselx  <= dec_sel;
              paddr  <= req_addr;
              pwdata <= req_wdata;
              pwrite <= req_write;
              state  <= SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= 8'h0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            pselx     <= 3'b000;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? 32'h0 : prdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIM) begin
            pselx     <= 3'b000;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
